mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Iterative multiply/divide unit for the RV32M/RV64M extension, successor to the single-cycle ALU decode path.
//  Decodes funct3 of OP/funct7=0000001 instructions and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Radix-2 shift-add multiply and restoring divide, one bit per clock.
//  Sits beside the main ALU in execute; the control unit stalls the pipeline while Busy is high.
// PARAMETERS
//  XLEN      32  operand/result width (32 or 64)
//  CNT_W     $clog2(XLEN)+1  iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst_n      in   1     asynchronous reset, active low
//  Start      in   1     request; sampled only in IDLE or DONE
//  funct3     in   3     M-op select (000 MUL .. 111 REMU)
//  SrcA       in   XLEN  rs1 operand (multiplicand / dividend)
//  SrcB       in   XLEN  rs2 operand (multiplier / divisor)
//  Flush      in   1     synchronous abort of the in-flight op
//  Busy       out  1     high while in CALC
//  Done       out  1     one-cycle pulse, Result valid this cycle onward
//  Result     out  XLEN  registered result, held until next accepted Start
// BEHAVIOUR
//  Reset: state=IDLE, Busy=0, Done=0, Result=0, counter=0, all datapath regs=0.
//  FSM IDLE -> CALC (Start, normal op) | DONE (Start, special case); CALC -> DONE when counter hits 0; DONE -> IDLE, or
//   -> CALC/DONE directly if Start in DONE (back-to-back, no bubble).
//  Start accepted: latch funct3, operands, operand signs; Start while Busy is ignored (no queueing).
//  Sign handling: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
//   Core operates on magnitudes; final negation applied in the DONE transition.
//  Multiply: 2*XLEN product reg; MUL returns product[XLEN-1:0], MULH* return product[2*XLEN-1:XLEN].
//  Divide: quotient sign = signA^signB; remainder sign = signA (dividend).
//  Latency: Start cycle = T; normal op -> Done at T+XLEN+1 (XLEN CALC cycles + DONE cycle).
//  Special cases resolved without CALC, Done at T+1:
//   divisor==0: DIV/DIVU quotient = all ones; REM/REMU = SrcA.
//   signed overflow SrcA==MIN_INT, SrcB==-1: DIV = MIN_INT, REM = 0.
//  Flush: any state -> IDLE next edge, Busy=0, Done not asserted, Result unchanged; Flush beats Start same cycle.
//  Reset asserted mid-op: immediate return to reset values; no partial Result visible.
//  Counter decrements modulo CNT_W, never wraps in CALC (exit at 0); Done is never high two consecutive cycles
//   except on back-to-back special-case ops.
// STRUCTURE
//  Package rv_m_pkg: typedef enum logic [2:0] mdu_op_t {MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU} matching funct3;
//   typedef enum mdu_state_t {IDLE,CALC,DONE}; helper functions is_div(op), a_signed(op), b_signed(op).
//  One sub-module: mdu_step — combinational single-iteration step (add-shift for mul, trial-subtract for div),
//   XLEN-parametrised; top holds FSM, counter, sign/special-case logic and Result register.
// TESTING (XLEN=32)
//  MUL 7 x -3 -> Done at T+33, Result=0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7 / 2 -> -3 (0xFFFFFFFD); REM -7 / 2 -> -1; DIVU 100 / 7 -> 14; REMU -> 2.
//  DIV x/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0, both T+1.
//  Flush at T+10 of DIV -> IDLE next cycle, no Done, Result keeps prior value; Start during Busy ignored.
//  rst_n low at T+5 of MUL -> all outputs 0 asynchronously; back-to-back Start in DONE -> second Done at +33.

Source files
------------

// File: rtl/rv_m_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M/RV64M multiply/divide unit.
package rv_m_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return op inside {REM, REMU};
  endfunction

  function automatic logic a_signed(input mdu_op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic b_signed(input mdu_op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic                div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;
  logic [XLEN-1:0] rem_n_s;
  logic            qbit_s;

  // Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum_s     = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (acc_i[0] ? b_i : {XLEN{1'b0}})};
    shifted_s = acc_i[2*XLEN-1:XLEN-1];
    diff_s    = shifted_s - {1'b0, b_i};
    if (diff_s[XLEN]) begin
      rem_n_s = shifted_s[XLEN-1:0];
      qbit_s  = 1'b0;
    end else begin
      rem_n_s = diff_s[XLEN-1:0];
      qbit_s  = 1'b1;
    end
    if (div_i) begin
      acc_o = {rem_n_s, acc_i[XLEN-2:0], qbit_s};
    end else begin
      acc_o = {sum_s, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative M-extension unit: FSM, iteration counter, sign and special-case handling, Result register.
module mdu_iterative
  import rv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_op_t           op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  mdu_op_t           op_s;
  logic              sa_s, sb_s, special_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, special_res_s;
  logic [2*XLEN-1:0] step_acc_s, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res_s;

  mdu_step #(.XLEN(XLEN)) u_step (
    .div_i (is_div(op_q)),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (step_acc_s)
  );

  // Decode the incoming request: signs, magnitudes and the no-iteration divide cases.
  always_comb begin
    op_s      = mdu_op_t'(funct3);
    sa_s      = a_signed(op_s) & SrcA[XLEN-1];
    sb_s      = b_signed(op_s) & SrcB[XLEN-1];
    mag_a_s   = sa_s ? -SrcA : SrcA;
    mag_b_s   = sb_s ? -SrcB : SrcB;
    special_s = 1'b0;
    if (SrcB == {XLEN{1'b0}}) begin
      special_s     = is_div(op_s);
      special_res_s = is_rem(op_s) ? SrcA : {XLEN{1'b1}};
    end else begin
      special_s     = (op_s == DIV || op_s == REM) && (SrcA == MIN_INT) && (SrcB == {XLEN{1'b1}});
      special_res_s = is_rem(op_s) ? {XLEN{1'b0}} : MIN_INT;
    end
  end

  // Sign fix-up of the final iteration's output, applied on the way into DONE.
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -step_acc_s : step_acc_s;
    quo_s  = (sa_q ^ sb_q) ? -step_acc_s[XLEN-1:0] : step_acc_s[XLEN-1:0];
    rem_s  = sa_q ? -step_acc_s[2*XLEN-1:XLEN] : step_acc_s[2*XLEN-1:XLEN];
    case (op_q)
      MUL:                  final_res_s = prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU:  final_res_s = prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:            final_res_s = quo_s;
      REM, REMU:            final_res_s = rem_s;
      default:              final_res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state and datapath control; Flush wins over everything else.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            op_d = op_s;
            sa_d = sa_s;
            sb_d = sb_s;
            if (special_s) begin
              state_d  = DONE;
              done_d   = 1'b1;
              result_d = special_res_s;
            end else begin
              state_d = CALC;
              busy_d  = 1'b1;
              cnt_d   = CNT_INIT;
              if (is_div(op_s)) begin
                acc_d = {{XLEN{1'b0}}, mag_a_s};
                b_d   = mag_b_s;
              end else begin
                acc_d = {{XLEN{1'b0}}, mag_b_s};
                b_d   = mag_a_s;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          acc_d = step_acc_s;
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = final_res_s;
          end else begin
            busy_d = 1'b1;
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      op_q     <= MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= {(2*XLEN){1'b0}};
      b_q      <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: reference model on longint arithmetic, monitor checks Result and Done timing.
module tb_mdu_iterative;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] last_res;

  mdu_iterative #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .funct3 (funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Flush  (Flush),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: begin
        if (b == 32'd0) p = -1;
        else if (a == MIN32 && b == 32'hFFFF_FFFF) p = sa;
        else p = sa / sb;
      end
      3'd5: p = (b == 32'd0) ? -1 : ua / ub;
      3'd6: begin
        if (b == 32'd0) p = sa;
        else if (a == MIN32 && b == 32'hFFFF_FFFF) p = 0;
        else p = sa % sb;
      end
      default: p = (b == 32'd0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == MIN32 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one request for one cycle; record the expected result and Done cycle when it should be accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    exp_t e;
    funct3 = op;
    SrcA   = a;
    SrcB   = b;
    Start  = 1'b1;
    if (expect_it) begin
      e.res = ref_model(op, a, b);
      e.due = cyc + (is_special(op, a, b) ? 1 : 33);
      sb_q.push_back(e);
      last_res = e.res;
    end
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no Done within 60 cycles, expected one");
    end
  endtask

  // Monitor: every Done pops one expectation and checks value and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && Done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: Done with Result %h at cycle %0d, none expected", Result, cyc);
      end else begin
        e = sb_q.pop_front();
        if (Result !== e.res) begin
          errors++;
          $display("FAIL result: got %h expected %h", Result, e.res);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: Done at cycle %0d expected %0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    Start    = 1'b0;
    Flush    = 1'b0;
    funct3   = 3'd0;
    SrcA     = 32'd0;
    SrcB     = 32'd0;
    #1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_result", Result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);  wait_done();
    issue(3'd1, MIN32, MIN32, 1'b1);          wait_done();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);  wait_done();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);  wait_done();
    issue(3'd5, 32'd100, 32'd7, 1'b1);        wait_done();
    issue(3'd7, 32'd100, 32'd7, 1'b1);        wait_done();
    issue(3'd4, 32'd1234, 32'd0, 1'b1);       wait_done();
    issue(3'd6, 32'd5, 32'd0, 1'b1);          wait_done();
    issue(3'd4, MIN32, 32'hFFFF_FFFF, 1'b1);  wait_done();
    issue(3'd6, MIN32, 32'hFFFF_FFFF, 1'b1);  wait_done();
    issue(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b1);  wait_done();
    issue(3'd7, 32'hDEAD_BEEF, 32'd0, 1'b1);  wait_done();
    // Back-to-back straight out of DONE, including two consecutive special cases
    issue(3'd5, 32'd9, 32'd0, 1'b1);
    issue(3'd6, 32'd17, 32'd0, 1'b1);         wait_done();
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1); wait_done();
    issue(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1); wait_done();
    repeat (3) @(posedge clk);
    #1;

    // Flush part-way through a divide: no Done, Result keeps prior value
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("busy_before_flush", {31'd0, Busy}, 32'd1);
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    check("busy_after_flush", {31'd0, Busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("result_after_flush", Result, last_res);

    // Flush beats Start in the same cycle
    Flush = 1'b1;
    issue(3'd0, 32'd3, 32'd3, 1'b0);
    Flush = 1'b0;
    check("busy_flush_start", {31'd0, Busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Start while Busy is ignored
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    issue(3'd5, 32'd100, 32'd7, 1'b0);
    wait_done();
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations with occasional idle gaps
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(7, 0));
      case ($urandom_range(5, 0))
        0: begin a = MIN32; b = 32'hFFFF_FFFF; end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'($urandom_range(200, 0)); b = 32'($urandom_range(15, 1)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(op, a, b, 1'b1);
      wait_done();
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply
    issue(3'd0, 32'd11, 32'd13, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("busy_mid_op", {31'd0, Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_result", Result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("result_after_rst", Result, 32'd0);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected results never produced, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
